// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single-ported memory signals.
// The arbiter connects to the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        addr_err;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata, addr_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata, addr_err,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch, data) in front of one single-ported memory.
// Data normally wins; fetch wins after STARVE_LIMIT consecutive data grants it waited through.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and register the winner's request
// ACCESS | memory enabled for one cycle (suppressed on out-of-range address)
// RESP   | owner's ack pulse, read data / addr_err returned
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int MEM_DEPTH    = 256
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int          SW       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] SLIM   = SW'(STARVE_LIMIT);
    localparam logic [32:0] DEPTH_W  = 33'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          own_data_q, own_data_d;
    logic          err_q, err_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            own_data_q   <= 1'b0;
            err_q        <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            own_data_q   <= own_data_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        own_data_d   = own_data_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = mem_we_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    state_d = ACCESS;
                    if (bus.d_req && !(bus.f_req && starve_cnt_q == SLIM)) begin
                        own_data_d  = 1'b1;
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                        err_d       = {1'b0, bus.d_addr} >= DEPTH_W;
                        // Only count data grants that actually made fetch wait
                        if (bus.f_req && starve_cnt_q != SLIM) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end else begin
                        own_data_d   = 1'b0;
                        mem_addr_d   = bus.f_addr;
                        mem_we_d     = 1'b0;
                        mem_wdata_d  = '0;
                        err_d        = {1'b0, bus.f_addr} >= DEPTH_W;
                        starve_cnt_d = '0;
                    end
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d     = IDLE;
                own_data_d  = 1'b0;
                err_d       = 1'b0;
                mem_addr_d  = '0;
                mem_we_d    = 1'b0;
                mem_wdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    logic in_resp;
    logic rd_ok;

    assign in_resp       = (state_q == RESP);
    assign rd_ok         = in_resp && !err_q && !mem_we_q;

    assign bus.mem_en    = (state_q == ACCESS) && !err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.f_ack     = in_resp && !own_data_q;
    assign bus.d_ack     = in_resp && own_data_q;
    assign bus.f_rdata   = (rd_ok && !own_data_q) ? bus.mem_rdata : '0;
    assign bus.d_rdata   = (rd_ok && own_data_q) ? bus.mem_rdata : '0;
    assign bus.addr_err  = in_resp && err_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(3), .MEM_DEPTH(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
        n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %0b expected 0", bus.mem_en); end
        n_tests++; if ({bus.f_ack, bus.d_ack, bus.addr_err} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %0b expected 000", {bus.f_ack, bus.d_ack, bus.addr_err}); end
        n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", bus.mem_addr); end
    endtask

    task automatic test_fetch_only();
        bus.f_req = 1; bus.f_addr = 32'd5; bus.mem_rdata = 32'hDEADBEEF;
        @(negedge clock);   // ACCESS
        n_tests++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL fetch_mem_en: got %0b expected 1", bus.mem_en); end
        n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_we: got %0b expected 0", bus.mem_we); end
        n_tests++; if (bus.mem_addr !== 32'd5) begin n_fail++; $display("FAIL fetch_mem_addr: got %0h expected 5", bus.mem_addr); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_c1: got %0b expected 1", bus.busy); end
        @(negedge clock);   // RESP
        n_tests++; if (bus.f_ack !== 1'b1) begin n_fail++; $display("FAIL fetch_ack: got %0b expected 1", bus.f_ack); end
        n_tests++; if (bus.f_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rdata: got %0h expected deadbeef", bus.f_rdata); end
        n_tests++; if (bus.d_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_d_ack: got %0b expected 0", bus.d_ack); end
        n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL fetch_mem_en_resp: got %0b expected 0", bus.mem_en); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fetch_busy_c2: got %0b expected 1", bus.busy); end
        bus.f_req = 0;
        @(negedge clock);   // IDLE
        n_tests++; if (bus.f_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %0b expected 0", bus.f_ack); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fetch_busy_idle: got %0b expected 0", bus.busy); end
        n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL fetch_addr_idle: got %0h expected 0", bus.mem_addr); end
    endtask

    task automatic test_data_write();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'd10; bus.d_wdata = 32'h1234;
        bus.mem_rdata = 32'hCAFEF00D;
        @(negedge clock);
        n_tests++; if ({bus.mem_en, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL wr_en_we: got %0b expected 11", {bus.mem_en, bus.mem_we}); end
        n_tests++; if (bus.mem_addr !== 32'd10) begin n_fail++; $display("FAIL wr_addr: got %0h expected a", bus.mem_addr); end
        n_tests++; if (bus.mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL wr_wdata: got %0h expected 1234", bus.mem_wdata); end
        @(negedge clock);
        n_tests++; if (bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %0b expected 1", bus.d_ack); end
        n_tests++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %0h expected 0", bus.d_rdata); end
        n_tests++; if (bus.mem_wdata !== 32'h1234) begin n_fail++; $display("FAIL wr_wdata_hold: got %0h expected 1234", bus.mem_wdata); end
        bus.d_req = 0; bus.d_we = 0;
        @(negedge clock);
    endtask

    task automatic test_data_read();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd255; bus.mem_rdata = 32'h0BADF00D;
        @(negedge clock);
        n_tests++; if ({bus.mem_en, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL rd255_en_we: got %0b expected 10", {bus.mem_en, bus.mem_we}); end
        @(negedge clock);
        n_tests++; if (bus.d_rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL rd255_rdata: got %0h expected badf00d", bus.d_rdata); end
        n_tests++; if ({bus.addr_err, bus.f_ack} !== 2'b00) begin n_fail++; $display("FAIL rd255_err_fack: got %0b expected 00", {bus.addr_err, bus.f_ack}); end
        n_tests++; if (bus.f_rdata !== 32'h0) begin n_fail++; $display("FAIL rd255_f_rdata: got %0h expected 0", bus.f_rdata); end
        bus.d_req = 0;
        @(negedge clock);
    endtask

    task automatic test_out_of_range();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd256; bus.mem_rdata = 32'h55AA55AA;
        @(negedge clock);
        n_tests++; if (bus.mem_en !== 1'b0) begin n_fail++; $display("FAIL oor_mem_en: got %0b expected 0", bus.mem_en); end
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_access: got %0b expected 0", bus.addr_err); end
        @(negedge clock);
        n_tests++; if ({bus.d_ack, bus.addr_err} !== 2'b11) begin n_fail++; $display("FAIL oor_ack_err: got %0b expected 11", {bus.d_ack, bus.addr_err}); end
        n_tests++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %0h expected 0", bus.d_rdata); end
        bus.d_req = 0;
        @(negedge clock);
        n_tests++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_idle: got %0b expected 0", bus.addr_err); end
    endtask

    task automatic test_starvation();
        logic [7:0] exp_data;
        int         exp_cnt [8];
        exp_data = 8'b1110_1110;   // grant k uses bit 7-k: D,D,D,F,D,D,D,F
        exp_cnt  = '{1, 2, 3, 0, 1, 2, 3, 0};
        bus.mem_rdata = 32'h0; bus.d_we = 0;
        bus.f_req = 1; bus.f_addr = 32'd7; bus.d_req = 1; bus.d_addr = 32'd20;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            @(negedge clock);
            n_tests++; if ({bus.d_ack, bus.f_ack} !== {exp_data[7-k], ~exp_data[7-k]}) begin n_fail++; $display("FAIL starve_grant%0d: got d/f %0b expected %0b", k, {bus.d_ack, bus.f_ack}, {exp_data[7-k], ~exp_data[7-k]}); end
            n_tests++; if (int'(dut.starve_cnt_q) != exp_cnt[k]) begin n_fail++; $display("FAIL starve_cnt%0d: got %0d expected %0d", k, dut.starve_cnt_q, exp_cnt[k]); end
            if (k == 7) begin bus.f_req = 0; bus.d_req = 0; end
            @(negedge clock);
            n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL starve_idle%0d: got %0b expected 0", k, bus.busy); end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_op();
        bus.f_req = 1; bus.f_addr = 32'd9; bus.mem_rdata = 32'h13572468;
        @(negedge clock);   // ACCESS
        reset = 1; bus.f_req = 0;
        @(negedge clock);
        reset = 0;
        n_tests++; if ({bus.busy, bus.f_ack, bus.mem_en} !== 3'b000) begin n_fail++; $display("FAIL rstmid_outs: got %0b expected 000", {bus.busy, bus.f_ack, bus.mem_en}); end
        n_tests++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_addr: got %0h expected 0", bus.mem_addr); end
        @(negedge clock);
        n_tests++; if ({bus.busy, bus.f_ack} !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_ack: got %0b expected 00", {bus.busy, bus.f_ack}); end
        bus.f_req = 1;
        @(negedge clock);
        n_tests++; if (bus.mem_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_retry_en: got %0b expected 1", bus.mem_en); end
        @(negedge clock);
        n_tests++; if (bus.f_rdata !== 32'h13572468 || bus.f_ack !== 1'b1) begin n_fail++; $display("FAIL rstmid_retry_ack: got ack %0b data %0h expected 1 13572468", bus.f_ack, bus.f_rdata); end
        bus.f_req = 0;
        @(negedge clock);
    endtask

    task automatic test_dropped_req();
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'd3; bus.mem_rdata = 32'h0000ABCD;
        @(negedge clock);   // ACCESS
        bus.d_req = 0;
        @(negedge clock);
        n_tests++; if (bus.d_ack !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got %0b expected 1", bus.d_ack); end
        n_tests++; if (bus.d_rdata !== 32'h0000ABCD) begin n_fail++; $display("FAIL drop_rdata: got %0h expected abcd", bus.d_rdata); end
        @(negedge clock);
        @(negedge clock);
        n_tests++; if ({bus.busy, bus.mem_en, bus.d_ack} !== 3'b000) begin n_fail++; $display("FAIL drop_no_regrant: got %0b expected 000", {bus.busy, bus.mem_en, bus.d_ack}); end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_data_write();
        test_data_read();
        test_out_of_range();
        test_reset();
        test_starvation();
        test_reset_mid_op();
        test_dropped_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- STARVE_LIMIT, 3, consecutive data grants allowed while fetch waits
- MEM_DEPTH, 256, number of valid word addresses
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock  in  1  single clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, held until f_ack
- f_addr  in  32  fetch word address
- f_ack  out  1  fetch transaction complete, one-cycle pulse
- f_rdata  out  32  fetch read data, valid only while f_ack=1
- d_req  in  1  data/stack request, held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data word address
- d_wdata  in  32  data write value
- d_ack  out  1  data transaction complete, one-cycle pulse
- d_rdata  out  32  data read value, valid only while d_ack=1
- addr_err  out  1  high with the ack when the granted address is >= MEM_DEPTH
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en
- busy  out  1  high whenever the state is not IDLE
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, named clock and reset.

Function
REQ-004 The FSM SHALL have three states: IDLE, ACCESS and RESP. Transitions: IDLE->ACCESS when f_req|d_req; ACCESS->RESP always; RESP->IDLE always.
REQ-005 In IDLE with a request pending, the block SHALL pick the owner, register its address, we and wdata into mem_addr, mem_we and mem_wdata, and latch the owner.
REQ-006 Arbitration in IDLE SHALL work as follows:
- only one request pending: that requester wins
- both pending: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins
REQ-007 starve_cnt SHALL behave as follows:
- increment on each data grant made while f_req=1
- saturate at STARVE_LIMIT
- clear to 0 on any fetch grant
REQ-008 In ACCESS, mem_en SHALL be 1 for exactly one cycle. mem_en SHALL be 0 if the latched address is >= MEM_DEPTH.
REQ-009 mem_we SHALL equal 1 in ACCESS only for a data write. A fetch SHALL never write.
REQ-010 In RESP, the owner's ack SHALL be 1 for exactly one cycle; the other ack SHALL be 0.
REQ-011 In RESP, owner rdata SHALL equal mem_rdata for an in-range read. It SHALL be 0 for a write or an out-of-range access. Non-owner rdata SHALL be 0.
REQ-012 addr_err SHALL be 1 only in RESP, and only for an out-of-range access.
REQ-013 Latency SHALL be a request seen in IDLE at cycle n producing an ack in cycle n+2. Maximum throughput SHALL be one transaction per 3 cycles.
REQ-014 A request dropped after grant SHALL NOT abort the transaction; the ack is still issued.
REQ-015 Requesters SHALL deassert req the cycle after ack. The block re-arbitrates only in IDLE, so no duplicate grant occurs.
REQ-016 mem_addr, mem_we and mem_wdata SHALL hold stable from ACCESS through RESP and SHALL return to 0 in IDLE.

Reset
REQ-017 While reset=1 at a clock edge, the block SHALL do all of the following:
- state <= IDLE
- starve_cnt <= 0
- owner cleared
- all outputs 0 in the following cycle
REQ-018 Reset asserted in ACCESS or RESP SHALL abort the transaction with no ack issued. The next transaction SHALL start only from IDLE after reset deasserts.

Verification
REQ-019 Fetch only: f_req=1, f_addr=5, mem_rdata=0xDEADBEEF -> mem_en=1 in cycle 1, f_ack=1 with f_rdata=0xDEADBEEF in cycle 2, busy=1 in cycles 1-2.
REQ-020 Data write: d_req=1, d_we=1, d_addr=10, d_wdata=0x1234 -> in ACCESS, mem_en=1, mem_we=1, mem_addr=10, mem_wdata=0x1234; in RESP, d_ack=1, d_rdata=0.
REQ-021 Starvation: f_req and d_req held high continuously (d_req re-raised each IDLE) -> grant order D,D,D,F,D,D,D,F; starve_cnt returns to 0 after each F.
REQ-022 Out of range: d_addr=256 read -> mem_en stays 0; in RESP, d_ack=1, addr_err=1, d_rdata=0.
REQ-023 Reset mid-op: reset pulsed during ACCESS of a fetch -> no f_ack, busy=0 and all outputs 0 next cycle; a subsequent f_req completes normally with 2-cycle latency.
REQ-024 Dropped request: d_req deasserted in ACCESS -> d_ack still pulses in RESP; no new grant in the following IDLE.
